// File: rtl/sram_arb_pkg.sv
// Shared encodings for the SRAM port arbiter: FSM states, owner codes, latency bound.
package sram_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_WAIT = 1'b1
  } arb_state_e;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_e;

  localparam int READ_LAT_MAX = 4;

endpackage

// File: rtl/sram_port_arbiter_pick.sv
// Two-way combinational pick: req[1] = data, req[0] = inst, one-hot gnt.
// SRAM_ARB_RR_EN selects round-robin on `last`; otherwise data has fixed priority.
module arb_pick2
  import sram_arb_pkg::*;
(
  input  logic [1:0] req,
  input  owner_e     last,
  output logic [1:0] gnt
);

`ifdef SRAM_ARB_RR_EN
  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = (last == OWN_DATA) ? 2'b01 : 2'b10;
    end
  end
`else
  logic unused_last;
  assign unused_last = last;

  always_comb begin
    gnt = req;
    if (req[1]) begin
      gnt = 2'b10;
    end
  end
`endif

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one synchronous SRAM port between fetch and load/store, tracks the single
// outstanding read and routes its data back. SRAM_ARB_RR_EN enables round-robin.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int READ_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_gnt,
  output logic        inst_rvalid,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic [3:0]  data_wen,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_gnt,
  output logic        data_rvalid,
  output logic [31:0] data_rdata,
  output logic        sram_en,
  output logic [3:0]  sram_wen,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata,
  output logic        stallreq_for_arb
);

  if (READ_LAT < 1 || READ_LAT > READ_LAT_MAX) begin : g_bad_lat
    $error("sram_port_arbiter: READ_LAT out of range 1..4");
  end

  arb_state_e state;
  logic [2:0] cnt;
  owner_e     owner;
  owner_e     last_sel;

  logic       arb_open;
  logic       resp;
  logic [1:0] req;
  logic [1:0] gnt;
  logic       rd_grant;

`ifdef SRAM_ARB_RR_EN
  owner_e last;

  always_ff @(posedge clk) begin
    if (rst) begin
      last <= OWN_INST;
    end else if (|gnt) begin
      last <= gnt[1] ? OWN_DATA : OWN_INST;
    end
  end

  assign last_sel = last;
`else
  assign last_sel = OWN_INST;
`endif

  // The response cycle doubles as an arbitration slot so reads can overlap.
  assign arb_open = ~rst & ((state == ARB_IDLE) | (cnt == 3'd1));
  assign resp     = (state == ARB_WAIT) & (cnt == 3'd1);
  assign req      = {data_req, inst_req} & {2{arb_open}};

  arb_pick2 u_pick (
    .req  (req),
    .last (last_sel),
    .gnt  (gnt)
  );

  assign inst_gnt = gnt[0];
  assign data_gnt = gnt[1];
  assign rd_grant = inst_gnt | (data_gnt & (data_wen == 4'b0000));

  assign stallreq_for_arb = (inst_req & ~inst_gnt) | (data_req & ~data_gnt);

  always_comb begin
    sram_en    = 1'b0;
    sram_wen   = 4'b0000;
    sram_addr  = 32'h0;
    sram_wdata = 32'h0;
    if (data_gnt) begin
      sram_en    = 1'b1;
      sram_wen   = data_wen;
      sram_addr  = data_addr;
      sram_wdata = data_wdata;
    end else if (inst_gnt) begin
      sram_en    = 1'b1;
      sram_addr  = inst_addr;
    end
  end

  assign inst_rvalid = resp & (owner == OWN_INST);
  assign data_rvalid = resp & (owner == OWN_DATA);
  assign inst_rdata  = inst_rvalid ? sram_rdata : 32'h0;
  assign data_rdata  = data_rvalid ? sram_rdata : 32'h0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ARB_IDLE;
      cnt   <= 3'd0;
      owner <= OWN_INST;
    end else if (rd_grant) begin
      state <= ARB_WAIT;
      cnt   <= 3'(READ_LAT);
      owner <= data_gnt ? OWN_DATA : OWN_INST;
    end else if (state == ARB_WAIT) begin
      cnt <= cnt - 3'd1;
      if (cnt == 3'd1) begin
        state <= ARB_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench: READ_LAT=1 and READ_LAT=3 instances share stimulus; each step
// checks only the instance it targets.
module tb_sram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        data_req;
  logic [3:0]  data_wen;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] sram_rdata;

  logic        inst_gnt_1, inst_rvalid_1, data_gnt_1, data_rvalid_1, sram_en_1, stall_1;
  logic [31:0] inst_rdata_1, data_rdata_1, sram_addr_1, sram_wdata_1;
  logic [3:0]  sram_wen_1;
  logic        inst_gnt_3, inst_rvalid_3, data_gnt_3, data_rvalid_3, sram_en_3, stall_3;
  logic [31:0] inst_rdata_3, data_rdata_3, sram_addr_3, sram_wdata_3;
  logic [3:0]  sram_wen_3;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sram_port_arbiter #(.READ_LAT(1)) u1 (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_gnt(inst_gnt_1),
    .inst_rvalid(inst_rvalid_1), .inst_rdata(inst_rdata_1),
    .data_req(data_req), .data_wen(data_wen), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_gnt(data_gnt_1), .data_rvalid(data_rvalid_1),
    .data_rdata(data_rdata_1), .sram_en(sram_en_1), .sram_wen(sram_wen_1),
    .sram_addr(sram_addr_1), .sram_wdata(sram_wdata_1), .sram_rdata(sram_rdata),
    .stallreq_for_arb(stall_1)
  );

  sram_port_arbiter #(.READ_LAT(3)) u3 (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_gnt(inst_gnt_3),
    .inst_rvalid(inst_rvalid_3), .inst_rdata(inst_rdata_3),
    .data_req(data_req), .data_wen(data_wen), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_gnt(data_gnt_3), .data_rvalid(data_rvalid_3),
    .data_rdata(data_rdata_3), .sram_en(sram_en_3), .sram_wen(sram_wen_3),
    .sram_addr(sram_addr_3), .sram_wdata(sram_wdata_3), .sram_rdata(sram_rdata),
    .stallreq_for_arb(stall_3)
  );

  logic any_1, any_3;
  assign any_1 = |{inst_gnt_1, inst_rvalid_1, inst_rdata_1, data_gnt_1, data_rvalid_1,
                   data_rdata_1, sram_en_1, sram_wen_1, sram_addr_1, sram_wdata_1, stall_1};
  assign any_3 = |{inst_gnt_3, inst_rvalid_3, inst_rdata_3, data_gnt_3, data_rvalid_3,
                   data_rdata_3, sram_en_3, sram_wen_3, sram_addr_3, sram_wdata_3, stall_3};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; inst_req = 1'b0; inst_addr = '0; data_req = 1'b0;
    data_wen = '0; data_addr = '0; data_wdata = '0; sram_rdata = '0;
    tick(); tick();
    rst = 1'b0;

    // reset state
    @(negedge clk);
    chk("rst_zero_1", 32'(any_1), 32'd0);
    chk("rst_zero_3", 32'(any_3), 32'd0);
    $display("[TB] reset state checked");

    // lone fetch, READ_LAT=1
    tick();
    inst_req = 1'b1; inst_addr = 32'h0000_1000;
    @(negedge clk);
    chk("fetch_gnt", 32'(inst_gnt_1), 32'd1);
    chk("fetch_en", 32'(sram_en_1), 32'd1);
    chk("fetch_addr", sram_addr_1, 32'h0000_1000);
    chk("fetch_wen", 32'(sram_wen_1), 32'd0);
    chk("fetch_stall_t", 32'(stall_1), 32'd0);
    tick();
    inst_req = 1'b0; sram_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("fetch_rvalid", 32'(inst_rvalid_1), 32'd1);
    chk("fetch_rdata", inst_rdata_1, 32'hDEAD_BEEF);
    chk("fetch_no_drv", 32'(data_rvalid_1), 32'd0);
    chk("fetch_stall_t1", 32'(stall_1), 32'd0);
    tick();
    @(negedge clk);
    chk("fetch_rvalid_end", 32'(inst_rvalid_1), 32'd0);
    chk("fetch_rdata_end", inst_rdata_1, 32'd0);
    $display("[TB] lone fetch done");

    // simultaneous read requests; after reset both modes favour data
    do_reset();
    inst_req = 1'b1; inst_addr = 32'h0000_1004;
    data_req = 1'b1; data_wen = 4'b0000; data_addr = 32'h0000_3000;
    @(negedge clk);
    chk("sim_data_gnt", 32'(data_gnt_1), 32'd1);
    chk("sim_inst_wait", 32'(inst_gnt_1), 32'd0);
    chk("sim_stall", 32'(stall_1), 32'd1);
    chk("sim_addr", sram_addr_1, 32'h0000_3000);
    tick();
    data_req = 1'b0; sram_rdata = 32'h1111_2222;
    @(negedge clk);
    chk("sim_inst_gnt", 32'(inst_gnt_1), 32'd1);
    chk("sim_stall_end", 32'(stall_1), 32'd0);
    chk("sim_drvalid", 32'(data_rvalid_1), 32'd1);
    chk("sim_drdata", data_rdata_1, 32'h1111_2222);
    chk("sim_addr2", sram_addr_1, 32'h0000_1004);
    tick();
    inst_req = 1'b0; sram_rdata = 32'h3333_4444;
    @(negedge clk);
    chk("sim_irvalid", 32'(inst_rvalid_1), 32'd1);
    chk("sim_irdata", inst_rdata_1, 32'h3333_4444);
    chk("sim_dr_idle", 32'(data_rvalid_1), 32'd0);
    $display("[TB] simultaneous after reset done");

    // lone data read, then both request in its response cycle (last = data)
    tick();
    data_req = 1'b1; data_addr = 32'h0000_3008;
    @(negedge clk);
    chk("lr_data_gnt", 32'(data_gnt_1), 32'd1);
    tick();
    inst_req = 1'b1; inst_addr = 32'h0000_1008; data_addr = 32'h0000_300C;
    sram_rdata = 32'h5555_6666;
    @(negedge clk);
    chk("lr_drvalid", 32'(data_rvalid_1), 32'd1);
    chk("lr_drdata", data_rdata_1, 32'h5555_6666);
`ifdef SRAM_ARB_RR_EN
    chk("lr_rr_inst_gnt", 32'(inst_gnt_1), 32'd1);
    chk("lr_rr_data_wait", 32'(data_gnt_1), 32'd0);
    tick();
    inst_req = 1'b0;
    @(negedge clk);
    chk("lr_rr_data_next", 32'(data_gnt_1), 32'd1);
`else
    chk("lr_fp_data_gnt", 32'(data_gnt_1), 32'd1);
    chk("lr_fp_inst_wait", 32'(inst_gnt_1), 32'd0);
    tick();
    data_req = 1'b0;
    @(negedge clk);
    chk("lr_fp_inst_next", 32'(inst_gnt_1), 32'd1);
`endif
    tick();
    inst_req = 1'b0; data_req = 1'b0;
    $display("[TB] arbitration with last=data done");

    // back-to-back stores
    do_reset();
    data_req = 1'b1; data_wen = 4'b0011; data_addr = 32'h0000_2004; data_wdata = 32'h0000_ABCD;
    @(negedge clk);
    chk("st1_gnt", 32'(data_gnt_1), 32'd1);
    chk("st1_wen", 32'(sram_wen_1), 32'h3);
    chk("st1_addr", sram_addr_1, 32'h0000_2004);
    chk("st1_wdata", sram_wdata_1, 32'h0000_ABCD);
    tick();
    data_wen = 4'b1100; data_addr = 32'h0000_2008; data_wdata = 32'h1234_0000;
    @(negedge clk);
    chk("st2_gnt", 32'(data_gnt_1), 32'd1);
    chk("st2_wen", 32'(sram_wen_1), 32'hC);
    chk("st2_no_rvalid", 32'(data_rvalid_1), 32'd0);
    tick();
    data_req = 1'b0; data_wen = 4'b0000;
    @(negedge clk);
    chk("st_no_rvalid", 32'(data_rvalid_1), 32'd0);
    chk("st_en_off", 32'(sram_en_1), 32'd0);
    $display("[TB] stores done");

    // READ_LAT=3 back-to-back reads: grants T, T+3; rvalid T+3, T+6
    do_reset();
    inst_req = 1'b1; inst_addr = 32'h0000_0100;
    @(negedge clk);
    chk("l3_gnt_t0", 32'(inst_gnt_3), 32'd1);
    chk("l3_en_t0", 32'(sram_en_3), 32'd1);
    tick();
    inst_addr = 32'h0000_0104;
    @(negedge clk);
    chk("l3_gnt_t1", 32'(inst_gnt_3), 32'd0);
    chk("l3_en_t1", 32'(sram_en_3), 32'd0);
    chk("l3_stall_t1", 32'(stall_3), 32'd1);
    tick();
    @(negedge clk);
    chk("l3_en_t2", 32'(sram_en_3), 32'd0);
    chk("l3_rv_t2", 32'(inst_rvalid_3), 32'd0);
    tick();
    sram_rdata = 32'hA0A0_A0A0;
    @(negedge clk);
    chk("l3_rv_t3", 32'(inst_rvalid_3), 32'd1);
    chk("l3_rd_t3", inst_rdata_3, 32'hA0A0_A0A0);
    chk("l3_gnt_t3", 32'(inst_gnt_3), 32'd1);
    chk("l3_addr_t3", sram_addr_3, 32'h0000_0104);
    tick();
    inst_req = 1'b0;
    @(negedge clk);
    chk("l3_en_t4", 32'(sram_en_3), 32'd0);
    chk("l3_rv_t4", 32'(inst_rvalid_3), 32'd0);
    tick();
    @(negedge clk);
    chk("l3_rv_t5", 32'(inst_rvalid_3), 32'd0);
    tick();
    sram_rdata = 32'hB0B0_B0B0;
    @(negedge clk);
    chk("l3_rv_t6", 32'(inst_rvalid_3), 32'd1);
    chk("l3_rd_t6", inst_rdata_3, 32'hB0B0_B0B0);
    tick();
    @(negedge clk);
    chk("l3_rv_t7", 32'(inst_rvalid_3), 32'd0);
    $display("[TB] READ_LAT=3 back-to-back done");

    // reset in the middle of a READ_LAT=3 wait
    do_reset();
    inst_req = 1'b1; inst_addr = 32'h0000_0200;
    @(negedge clk);
    chk("rw_gnt", 32'(inst_gnt_3), 32'd1);
    tick();
    inst_req = 1'b0; sram_rdata = 32'hC0FF_EE00;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rw_rvalid", 32'(inst_rvalid_3), 32'd0);
      chk("rw_zero", 32'(any_3), 32'd0);
      tick();
    end
    $display("[TB] reset during wait done");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
